dsm_decimator: RTL and testbench



---
 rtl/dsm_rx_pkg.sv | 44 ++++
 rtl/cic_comb_stage.sv | 42 ++++
 rtl/dsm_decimator.sv | 217 +++++++++++++++++++++
 tb/tb_dsm_decimator.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_rx_pkg.sv
// -----------------------------------------------------------------------------
// dsm_rx_pkg
//   Shared constants, types and elaboration-time helpers for the delta-sigma
//   receive path (dsm_decimator and its comb stages).
//
//   Contents:
//     MAX_ORDER    highest supported CIC order
//     warm_cnt_t   counter type for the post-reset warm-up beats (0..MAX_ORDER)
//     acc_w()      integrator / comb word width for a given order and ratio
//     out_shift()  right shift that maps the biased comb result onto WIDTH bits
//     full_scale() CIC DC gain R^N
//     FULL_SCALE   R^N for the default configuration (R = 64, N = 3)
// -----------------------------------------------------------------------------
package dsm_rx_pkg;

  localparam int MAX_ORDER = 4;

  // Wide enough to count 0..MAX_ORDER warm-up beats.
  typedef logic [2:0] warm_cnt_t;

  // The comb result spans [-R^N, +R^N]. R^N = 2^(N*log2R) needs N*log2R+1
  // magnitude bits, plus a sign bit, hence the +2.
  function automatic int acc_w(input int order, input int log2_decim);
    return order * log2_decim + 2;
  endfunction

  // y + R^N lies in [0, 2^(N*log2R+1)]; dropping this many LSBs leaves a
  // value in [0, 2^width], where only the very top code needs clipping.
  function automatic int out_shift(input int order, input int log2_decim,
                                   input int width);
    return order * log2_decim + 1 - width;
  endfunction

  // DC gain of the CIC filter: R^N.
  function automatic longint full_scale(input int order, input int log2_decim);
    return longint'(1) << (order * log2_decim);
  endfunction

  localparam int     DEF_WIDTH      = 16;
  localparam int     DEF_LOG2_DECIM = 6;
  localparam int     DEF_ORDER      = 3;
  localparam longint FULL_SCALE     = full_scale(DEF_ORDER, DEF_LOG2_DECIM);

endpackage : dsm_rx_pkg

// File: rtl/cic_comb_stage.sv
// -----------------------------------------------------------------------------
// cic_comb_stage
//   One differentiator of the CIC comb section: y = x - x_delayed, where the
//   delay register samples x only on decimation beats. The difference is
//   combinational so a chain of stages settles within the beat cycle and the
//   top module registers the final result.
//
//   Ports:
//     clk_i    clock
//     arst_ni  asynchronous active-low reset (clears the delay to 0)
//     en_i     decimation beat strobe; loads the delay with x_i
//     x_i      stage input (two's complement, wrap-around)
//     y_o      stage output x_i - delay
// -----------------------------------------------------------------------------
module cic_comb_stage #(
  parameter int W = 20
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                en_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_o
);

  logic signed [W-1:0] dly_q;
  logic signed [W-1:0] dly_d;

  assign dly_d = en_i ? x_i : dly_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

  // Wrap-around subtraction: integrator overflow cancels out here as long as
  // the true result fits in W bits.
  assign y_o = x_i - dly_q;

endmodule : cic_comb_stage

// File: rtl/dsm_decimator.sv
// -----------------------------------------------------------------------------
// dsm_decimator
//   CIC (sinc^N) decimator for a 1-bit delta-sigma bitstream. Each accepted
//   bit enters N cascaded integrators as +1 (bit = 1) or -1 (bit = 0). Every
//   R-th accepted bit is a decimation beat: the last integrator value is run
//   through N comb stages and the result is biased and scaled into a WIDTH-bit
//   unsigned offset-binary sample. The first ORDER beats after reset only
//   prime the comb delays and emit nothing.
//
//   Parameters:
//     WIDTH       output sample width
//     LOG2_DECIM  log2 of the decimation ratio R
//     ORDER       CIC order N (1..4)
//
//   Ports:
//     aclk                clock
//     arst_n              asynchronous active-low reset
//     s_axis_data_tdata   bitstream bit (1 -> +1, 0 -> -1)
//     s_axis_data_tvalid  input bit valid
//     s_axis_data_tready  block can accept a bit
//     m_axis_data_tdata   decimated sample (offset binary)
//     m_axis_data_tvalid  sample valid
//     m_axis_data_tready  downstream accepts the sample
//     clip                one-cycle pulse alongside a saturated sample
//
//   Handshake: a transfer happens on a rising clock edge where both valid and
//   ready are high. The master side holds tvalid and tdata stable until the
//   transfer; tvalid never depends combinationally on tready. Input ready is
//   low only while an emitted sample waits for downstream, so a pending sample
//   is never overwritten and a new sample can replace one being taken in the
//   same cycle without a bubble.
// -----------------------------------------------------------------------------
module dsm_decimator
  import dsm_rx_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG2_DECIM = 6,
  parameter int ORDER      = 3
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [WIDTH-1:0] m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready,
  output logic             clip
);

  localparam int ACC_W = acc_w(ORDER, LOG2_DECIM);
  localparam int SHIFT = out_shift(ORDER, LOG2_DECIM, WIDTH);

  localparam logic [ACC_W-1:0] FS_OFFSET = ACC_W'(full_scale(ORDER, LOG2_DECIM));
  localparam warm_cnt_t        WARM_DONE = warm_cnt_t'(ORDER);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (ORDER < 1 || ORDER > MAX_ORDER) begin : g_bad_order
      $error("dsm_decimator: ORDER must be in 1..%0d", MAX_ORDER);
    end
    if (ORDER * LOG2_DECIM + 1 < WIDTH) begin : g_bad_width
      $error("dsm_decimator: ORDER*LOG2_DECIM+1 must be >= WIDTH");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic m_valid_q;
  logic m_valid_d;
  logic accept;
  logic beat;
  logic emit;

  assign s_axis_data_tready = !(m_valid_q && !m_axis_data_tready);
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;

  // ---------------------------------------------------------------------------
  // Integrators
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] integ_q [ORDER];
  logic signed [ACC_W-1:0] integ_d [ORDER];
  logic signed [ACC_W-1:0] step;

  // All-ones is -1 in two's complement.
  assign step = s_axis_data_tdata ? ACC_W'(1) : '1;

  // Each stage adds the already-updated value of the stage before it, so the
  // whole cascade advances by one sample per accepted bit.
  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      integ_d[k] = integ_q[k];
    end
    if (accept) begin
      integ_d[0] = integ_q[0] + step;
      for (int k = 1; k < ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_d[k-1];
      end
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= integ_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decimation and warm-up counters
  // ---------------------------------------------------------------------------
  logic [LOG2_DECIM-1:0] cnt_q;
  logic [LOG2_DECIM-1:0] cnt_d;
  warm_cnt_t             warm_q;
  warm_cnt_t             warm_d;

  // R is a power of two, so the counter wraps from R-1 to 0 by itself.
  assign cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
  assign beat  = accept && (cnt_q == '1);

  // Saturates at ORDER: from then on every beat emits a sample.
  assign warm_d = (beat && (warm_q != WARM_DONE)) ? warm_q + 1'b1 : warm_q;
  assign emit   = beat && (warm_q == WARM_DONE);

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q  <= '0;
      warm_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      warm_q <= warm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Comb section: the beat's own post-update integrator value feeds stage 0,
  // so the result is ready in the beat cycle and registered at its edge.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] comb_x [ORDER+1];

  assign comb_x[0] = integ_d[ORDER-1];

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(
      .W (ACC_W)
    ) u_comb (
      .clk_i   (aclk),
      .arst_ni (arst_n),
      .en_i    (beat),
      .x_i     (comb_x[k]),
      .y_o     (comb_x[k+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Output mapping: bias by R^N to make it non-negative, then drop SHIFT LSBs.
  // The scaled value reaches 2^WIDTH only at positive full scale, so its top
  // bit alone flags saturation.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] biased;
  logic [WIDTH:0]   scaled;
  logic             sat;
  logic [WIDTH-1:0] sample;

  assign biased = comb_x[ORDER] + FS_OFFSET;
  assign scaled = (WIDTH+1)'(biased >> SHIFT);
  assign sat    = scaled[WIDTH];
  assign sample = sat ? '1 : scaled[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] m_data_q;
  logic [WIDTH-1:0] m_data_d;
  logic             clip_q;
  logic             clip_d;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    clip_d    = 1'b0;
    if (emit) begin
      // Only reachable when no sample is pending or the pending one is being
      // taken this cycle, since input ready gates every beat.
      m_valid_d = 1'b1;
      m_data_d  = sample;
      clip_d    = sat;
    end else if (m_axis_data_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      clip_q    <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      clip_q    <= clip_d;
    end
  end

  assign m_axis_data_tvalid = m_valid_q;
  assign m_axis_data_tdata  = m_data_q;
  assign clip               = clip_q;

endmodule : dsm_decimator

// File: tb/tb_dsm_decimator.sv
// -----------------------------------------------------------------------------
// tb_dsm_decimator
//   Self-checking bench for dsm_decimator (WIDTH=16, R=64, N=3). The reference
//   treats the CIC as its equivalent FIR filter: the impulse response is the
//   N-fold convolution of a length-R boxcar, applied to the full history of
//   accepted +/-1 bits at each decimation beat.
// -----------------------------------------------------------------------------
module tb_dsm_decimator;

  localparam int WIDTH      = 16;
  localparam int LOG2_DECIM = 6;
  localparam int ORDER      = 3;
  localparam int R          = 1 << LOG2_DECIM;
  localparam int HLEN       = ORDER * (R - 1) + 1;
  localparam longint FS     = longint'(1) << (ORDER * LOG2_DECIM);
  localparam int SHIFT      = ORDER * LOG2_DECIM + 1 - WIDTH;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             aclk     = 1'b0;
  logic             arst_n   = 1'b0;
  logic             s_tdata  = 1'b0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic             clip;

  always #5 aclk = ~aclk;

  dsm_decimator #(
    .WIDTH      (WIDTH),
    .LOG2_DECIM (LOG2_DECIM),
    .ORDER      (ORDER)
  ) dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .clip               (clip)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  int               h [HLEN];
  int               hist[$];
  int               bit_cnt = 0;
  int               beat_cnt = 0;
  logic [WIDTH:0]   exp_q[$];        // {clip, data}
  logic [WIDTH-1:0] got_q[$];
  bit               got_clip_q[$];
  bit               prev_hold = 1'b0;
  bit               expect_rise = 1'b0;
  int               first_valid_bits = -1;
  bit               src_q[$];

  bit rdy_rand    = 1'b0;
  int stall_start = -1000;
  int cyc         = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void build_h();
    int cur[$];
    int nxt[$];
    for (int i = 0; i < R; i++) cur.push_back(1);
    for (int s = 1; s < ORDER; s++) begin
      nxt = {};
      for (int i = 0; i < cur.size() + R - 1; i++) nxt.push_back(0);
      for (int i = 0; i < cur.size(); i++)
        for (int j = 0; j < R; j++) nxt[i+j] += cur[i];
      cur = nxt;
    end
    for (int i = 0; i < HLEN; i++) h[i] = cur[i];
  endfunction

  function automatic logic [WIDTH:0] model_sample();
    longint y = 0;
    longint u;
    int     n = hist.size();
    logic [WIDTH-1:0] d;
    for (int j = 0; j < HLEN; j++)
      if (n - 1 - j >= 0) y += longint'(h[j]) * hist[n-1-j];
    u = (y + FS) >>> SHIFT;
    if (u > (longint'(1) << WIDTH) - 1) return {1'b1, {WIDTH{1'b1}}};
    d = u[WIDTH-1:0];
    return {1'b0, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: runs every cycle on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge aclk) begin
    if (!arst_n) begin
      hist = {};
      exp_q = {};
      bit_cnt = 0;
      beat_cnt = 0;
      prev_hold = 1'b0;
      expect_rise = 1'b0;
      first_valid_bits = -1;
    end else begin
      check("tready_rule", s_tready, !(m_tvalid && !m_tready));
      if (expect_rise) begin
        check("latency_valid", m_tvalid, 1);
        expect_rise = 1'b0;
      end
      if (m_tvalid) begin
        if (first_valid_bits < 0) first_valid_bits = bit_cnt;
        if (!prev_hold) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", m_tvalid, 0);
          end else begin
            check("data_new", m_tdata, exp_q[0][WIDTH-1:0]);
            check("clip_new", clip, exp_q[0][WIDTH]);
            got_clip_q.push_back(clip);
          end
        end else begin
          check("clip_held", clip, 0);
        end
        if (m_tready && exp_q.size() > 0) begin
          check("data_xfer", m_tdata, exp_q[0][WIDTH-1:0]);
          got_q.push_back(m_tdata);
          void'(exp_q.pop_front());
        end
      end else begin
        check("clip_idle", clip, 0);
      end
      prev_hold = m_tvalid && !m_tready;
      if (s_tvalid && s_tready) begin
        hist.push_back(s_tdata ? 1 : -1);
        bit_cnt++;
        if (bit_cnt % R == 0) begin
          beat_cnt++;
          if (beat_cnt > ORDER) begin
            exp_q.push_back(model_sample());
            expect_rise = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      cyc++;
      if (cyc >= stall_start && cyc < stall_start + 200) m_tready = 1'b0;
      else if (rdy_rand) m_tready = ($urandom_range(0, 3) != 0);
      else m_tready = 1'b1;
    end
  end

  task automatic do_reset();
    s_tvalid = 1'b0;
    arst_n   = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    arst_n = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic send_bits(input int gap_pct);
    int idx   = 0;
    int guard = 0;
    bit acc;
    while (idx < src_q.size()) begin
      s_tdata  = src_q[idx];
      s_tvalid = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
      @(negedge aclk);
      acc = s_tvalid && s_tready;
      @(posedge aclk);
      #1;
      if (acc) idx++;
      guard++;
      if (guard > 20000) begin
        check("send_timeout", idx, src_q.size());
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    rdy_rand    = 1'b0;
    stall_start = -1000;
    while ((exp_q.size() > 0 || m_tvalid) && guard < 500) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // kind: 0 all ones, 1 all zeros, 2 alternating 1,0, 3 repeating 1,1,1,0
  task automatic run_pattern(input string name, input int kind,
                             input logic [WIDTH-1:0] lit_data, input bit lit_clip);
    do_reset();
    src_q = {};
    for (int i = 0; i < 6 * R; i++) begin
      case (kind)
        0:       src_q.push_back(1'b1);
        1:       src_q.push_back(1'b0);
        2:       src_q.push_back(i % 2 == 0);
        default: src_q.push_back(i % 4 != 3);
      endcase
    end
    got_q = {};
    got_clip_q = {};
    send_bits(0);
    drain();
    check({name, "_count"}, got_q.size(), 3);
    foreach (got_q[i]) check({name, "_lit_data"}, got_q[i], lit_data);
    foreach (got_clip_q[i]) check({name, "_lit_clip"}, got_clip_q[i], lit_clip);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] run_a[$];

  initial begin
    build_h();
    do_reset();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_clip", clip, 0);
    check("rst_tready", s_tready, 1);

    run_pattern("ones", 0, 16'hFFFF, 1'b1);
    run_pattern("zeros", 1, 16'h0000, 1'b0);
    run_pattern("alt", 2, 16'h8000, 1'b0);
    run_pattern("three_q", 3, 16'hC000, 1'b0);

    // Random bitstream, gapless, then again with input gaps and output stalls.
    do_reset();
    src_q = {};
    for (int i = 0; i < 20 * R; i++) src_q.push_back(1'($urandom_range(0, 1)));
    got_q = {};
    send_bits(0);
    drain();
    check("gapless_count", got_q.size(), 17);
    run_a = got_q;

    do_reset();
    got_q = {};
    rdy_rand    = 1'b1;
    stall_start = cyc + 300;
    send_bits(30);
    drain();
    check("gapped_bits", bit_cnt, src_q.size());
    check("gapped_count", got_q.size(), run_a.size());
    foreach (run_a[i])
      if (i < got_q.size()) check("gapped_vs_gapless", got_q[i], run_a[i]);

    // Reset in the middle of frame 5 (30 bits in), then restart from scratch.
    do_reset();
    src_q = {};
    for (int i = 0; i < 5 * R + 30; i++) src_q.push_back(1'($urandom_range(0, 1)));
    send_bits(0);
    #2;
    arst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_tdata", m_tdata, 0);
    check("midrst_clip", clip, 0);
    check("midrst_tready", s_tready, 1);
    @(negedge aclk);
    @(negedge aclk);
    arst_n = 1'b1;
    @(posedge aclk);
    #1;
    src_q = {};
    for (int i = 0; i < 300; i++) src_q.push_back(1'($urandom_range(0, 1)));
    got_q = {};
    send_bits(0);
    drain();
    check("restart_first_valid_bits", first_valid_bits, 256);
    check("restart_count", got_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dsm_decimator
